issue_sched: RTL and testbench

//  Issue scheduler for the IF/ID instruction buffer. Decides each cycle whether buffer slot 0 and slot 1

---
 rtl/issue_sched_if.sv | 48 ++++
 rtl/issue_sched.sv | 181 ++++++++++++++++++
 tb/tb_issue_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_sched_if.sv
//------------------------------------------------------------------------------
// Module   : issue_sched_if
// Purpose  : Bundles the signals between the IF/ID instruction buffer, the
//            writeback stage and the issue scheduler.
// Signals  : branch_flag   mispredict flush
//            id_stall      ID cannot accept this cycle
//            sendout_flag1 buffer slot 0 valid
//            sendout_flag2 buffer slot 1 valid
//            inst1 / inst2 slot 0 / slot 1 instructions (32 bit)
//            wb_ld_valid   load result written back this cycle
//            wb_ld_rd      destination register of that load
//            launch_flag1  slot 0 consumed at next posedge
//            launch_flag2  slot 1 consumed at next posedge
//            sb_busy       load scoreboard, bit r = load to xr in flight
//            sched_state   00 RUN, 01 FLUSH, 10 DRAIN
// Modports : master = buffer/writeback side, slave = scheduler
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface issue_sched_if;
  logic        branch_flag;
  logic        id_stall;
  logic        sendout_flag1;
  logic        sendout_flag2;
  logic [31:0] inst1;
  logic [31:0] inst2;
  logic        wb_ld_valid;
  logic [4:0]  wb_ld_rd;
  logic        launch_flag1;
  logic        launch_flag2;
  logic [31:0] sb_busy;
  logic [1:0]  sched_state;

  modport master (
    output branch_flag, id_stall, sendout_flag1, sendout_flag2,
           inst1, inst2, wb_ld_valid, wb_ld_rd,
    input  launch_flag1, launch_flag2, sb_busy, sched_state
  );

  modport slave (
    input  branch_flag, id_stall, sendout_flag1, sendout_flag2,
           inst1, inst2, wb_ld_valid, wb_ld_rd,
    output launch_flag1, launch_flag2, sb_busy, sched_state
  );
endinterface

`default_nettype wire

// File: rtl/issue_sched.sv
//------------------------------------------------------------------------------
// Module   : issue_sched
// Purpose  : Issue scheduler for the IF/ID instruction buffer. Decides each
//            cycle whether slot 0 / slot 1 launch to ID, enforcing load-use,
//            intra-pair and serialization hazards, and holds launch off
//            across branch flushes. Holds a load scoreboard, a RUN/FLUSH/DRAIN
//            sequencer and its hold counter.
// Ports    : clk  - clock, all state updates on posedge
//            rst  - synchronous active-high reset
//            bus  - issue_sched_if.slave (buffer, writeback and status signals)
// Params   : FLUSH_CYCLES - launch hold-off after branch_flag (min 1)
//            DRAIN_CYCLES - launch hold-off after a serializing instr (min 1)
// Config   : DUAL_ISSUE_EN - when defined slot 1 may launch alongside slot 0;
//            otherwise launch_flag2 is tied low (single issue).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module issue_sched #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  issue_sched_if.slave  bus
);

  localparam int MAX_HOLD = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    DRAIN = 2'b10
  } state_t;

  typedef struct packed {
    logic       rd_used;
    logic       rs1_used;
    logic       rs2_used;
    logic       ctrl;
    logic       mem;
    logic       load;
    logic       serial;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    logic [6:0] op;
    op       = inst[6:0];
    d.rd     = inst[11:7];
    d.rs1    = inst[19:15];
    d.rs2    = inst[24:20];
    d.rd_used  = (op == OP_LUI || op == OP_AUIPC || op == OP_JAL || op == OP_JALR ||
                  op == OP_LOAD || op == OP_IMM || op == OP_OP) && (inst[11:7] != 5'd0);
    d.rs1_used = (op == OP_JALR || op == OP_BRANCH || op == OP_LOAD || op == OP_STORE ||
                  op == OP_IMM || op == OP_OP);
    d.rs2_used = (op == OP_BRANCH || op == OP_STORE || op == OP_OP);
    d.ctrl     = (op == OP_JAL || op == OP_JALR || op == OP_BRANCH);
    d.mem      = (op == OP_LOAD || op == OP_STORE);
    d.load     = (op == OP_LOAD);
    d.serial   = (op == OP_MISC || op == OP_SYSTEM);
    return d;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       sb_q, sb_d;
  logic              launch1, launch2;
  dec_t              d1, d2;
  logic              hit1, hit2;

  assign d1 = decode(bus.inst1);
  assign d2 = decode(bus.inst2);

  // Only source fields the instruction actually reads can hit the scoreboard.
  assign hit1 = (d1.rs1_used & sb_q[d1.rs1]) | (d1.rs2_used & sb_q[d1.rs2]);
  assign hit2 = (d2.rs1_used & sb_q[d2.rs1]) | (d2.rs2_used & sb_q[d2.rs2]);

`ifdef DUAL_ISSUE_EN
  logic unused_dual;
  assign unused_dual = d2.ctrl;
`else
  logic unused_dual;
  assign unused_dual = ^{d1, d2, hit2, bus.sendout_flag2};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch2 = 1'b0;

    // A serializing instruction waits until every in-flight load has returned.
    launch1 = !rst && (state_q == RUN) && !bus.branch_flag && !bus.id_stall &&
              bus.sendout_flag1 && !hit1 && (!d1.serial || (sb_q == 32'd0));

`ifdef DUAL_ISSUE_EN
    launch2 = launch1 && bus.sendout_flag2 && !d1.serial && !d2.serial && !d1.ctrl &&
              !(d1.mem && d2.mem) && !hit2 &&
              !(d1.rd_used && ((d2.rs1_used && (d2.rs1 == d1.rd)) ||
                               (d2.rs2_used && (d2.rs2 == d1.rd)))) &&
              !(d1.rd_used && d2.rd_used && (d1.rd == d2.rd));
`endif

    case (state_q)
      RUN: begin
        if (bus.branch_flag) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (launch1 && d1.serial) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      FLUSH, DRAIN: begin
        // A new flush restarts the hold-off regardless of what was pending.
        if (bus.branch_flag) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear first so that a same-cycle launch of the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (bus.wb_ld_valid)
      sb_d[bus.wb_ld_rd] = 1'b0;
    if (launch1 && d1.load)
      sb_d[d1.rd] = 1'b1;
    if (launch2 && d2.load)
      sb_d[d2.rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sb_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
    end
  end

  assign bus.launch_flag1 = launch1;
  assign bus.launch_flag2 = launch2;
  assign bus.sb_busy      = sb_q;
  assign bus.sched_state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_issue_sched
// Purpose  : Self-checking bench for issue_sched. A behavioural model tracks
//            in-flight loads and the remaining hold-off cycles; a negedge
//            process compares every DUT output against it, and directed
//            vectors add hand-computed expectations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_issue_sched;

`ifdef DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  localparam int FLUSH_N = 1;
  localparam int DRAIN_N = 3;

  localparam logic [31:0] NOP       = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] ADDI_X1   = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] ADDI_X3   = 32'h0030_0193; // addi x3,x0,3
  localparam logic [31:0] ADD_X2_X1 = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] LW_X5     = 32'h0000_2283; // lw   x5,0(x0)
  localparam logic [31:0] LW_X7     = 32'h0000_2383; // lw   x7,0(x0)
  localparam logic [31:0] ADD_X6_X5 = 32'h0002_8333; // add  x6,x5,x0
  localparam logic [31:0] SW_X1     = 32'h0010_2023; // sw   x1,0(x0)
  localparam logic [31:0] JAL_X0    = 32'h0000_006f; // jal  x0,0
  localparam logic [31:0] FENCE     = 32'h0ff0_000f; // fence

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  issue_sched_if bus ();

  issue_sched #(.FLUSH_CYCLES(FLUSH_N), .DRAIN_CYCLES(DRAIN_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit rd_u(input logic [31:0] i);
    return (i[6:0] inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33}) && (i[11:7] != 5'd0);
  endfunction
  function automatic bit rs1_u(input logic [31:0] i);
    return i[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction
  function automatic bit rs2_u(input logic [31:0] i);
    return i[6:0] inside {7'h63, 7'h23, 7'h33};
  endfunction
  function automatic bit is_ctrl(input logic [31:0] i);
    return i[6:0] inside {7'h6f, 7'h67, 7'h63};
  endfunction
  function automatic bit is_mem(input logic [31:0] i);
    return i[6:0] inside {7'h03, 7'h23};
  endfunction
  function automatic bit is_serial(input logic [31:0] i);
    return i[6:0] inside {7'h0f, 7'h73};
  endfunction
  function automatic bit reads(input logic [31:0] i, input logic [4:0] r);
    return (rs1_u(i) && i[19:15] == r) || (rs2_u(i) && i[24:20] == r);
  endfunction

  bit [31:0] m_busy;        // registers with a load outstanding
  int        m_kind  = 0;   // 0 none, 1 flushing, 2 draining
  int        m_left  = 0;   // hold-off cycles still to come
  bit        m_valid = 1'b0;
  bit        e_l1, e_l2;

  function automatic bit busy_read(input logic [31:0] i);
    bit r;
    r = 1'b0;
    for (int k = 1; k < 32; k++)
      if (m_busy[k] && reads(i, 5'(k))) r = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin
    logic [31:0] i1, i2;
    i1 = bus.inst1;
    i2 = bus.inst2;
    e_l1 = !rst && m_kind == 0 && !bus.branch_flag && !bus.id_stall && bus.sendout_flag1 &&
           !busy_read(i1) && (!is_serial(i1) || m_busy == 0);
    e_l2 = DUAL && e_l1 && bus.sendout_flag2 && !is_serial(i1) && !is_serial(i2) &&
           !is_ctrl(i1) && !(is_mem(i1) && is_mem(i2)) && !busy_read(i2) &&
           !(rd_u(i1) && reads(i2, i1[11:7])) &&
           !(rd_u(i1) && rd_u(i2) && i1[11:7] == i2[11:7]);
    if (m_valid) begin
      chk("model_launch1", {31'd0, bus.launch_flag1}, {31'd0, e_l1});
      chk("model_launch2", {31'd0, bus.launch_flag2}, {31'd0, e_l2});
      chk("model_sb_busy", bus.sb_busy, m_busy);
      chk("model_state", {30'd0, bus.sched_state}, 32'(m_kind));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= '0;
      m_kind  <= 0;
      m_left  <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      bit [31:0] nb;
      nb = m_busy;
      if (bus.wb_ld_valid) nb[bus.wb_ld_rd] = 1'b0;
      if (e_l1 && bus.inst1[6:0] == 7'h03) nb[bus.inst1[11:7]] = 1'b1;
      if (e_l2 && bus.inst2[6:0] == 7'h03) nb[bus.inst2[11:7]] = 1'b1;
      nb[0] = 1'b0;
      m_busy <= nb;
      if (bus.branch_flag) begin
        m_kind <= 1;
        m_left <= FLUSH_N;
      end else if (m_kind != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_kind <= 0;
      end else if (e_l1 && is_serial(bus.inst1)) begin
        m_kind <= 2;
        m_left <= DRAIN_N;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v1, input bit v2, input logic [31:0] a, input logic [31:0] b);
    bus.sendout_flag1 = v1;
    bus.sendout_flag2 = v2;
    bus.inst1 = a;
    bus.inst2 = b;
  endtask

  task automatic lit(input string name, input bit l1, input bit l2);
    #1;
    chk({name, "_l1"}, {31'd0, bus.launch_flag1}, {31'd0, l1});
    chk({name, "_l2"}, {31'd0, bus.launch_flag2}, {31'd0, l2});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.branch_flag = 1'b0;
    bus.id_stall    = 1'b0;
    bus.wb_ld_valid = 1'b0;
    bus.wb_ld_rd    = 5'd0;
    drive(1, 0, ADDI_X1, NOP);

    // Reset with a valid slot 0
    tick; lit("rst_a", 0, 0);
    chk("rst_busy", bus.sb_busy, 32'd0);
    chk("rst_state", {30'd0, bus.sched_state}, 32'd0);
    tick; lit("rst_b", 0, 0);
    rst = 1'b0;

    // Intra-pair RAW, then independent pair, then WAW
    drive(1, 1, ADDI_X1, ADD_X2_X1); lit("raw_pair", 1, 0); tick;
    drive(1, 1, ADDI_X1, ADDI_X3);   lit("indep_pair", 1, DUAL); tick;
    drive(1, 1, ADDI_X1, ADDI_X1);   lit("waw_pair", 1, 0); tick;

    // ID stall and empty buffer
    bus.id_stall = 1'b1; lit("stall", 0, 0); tick;
    bus.id_stall = 1'b0;
    drive(0, 1, ADDI_X1, ADDI_X3); lit("empty", 0, 0); tick;
    chk("empty_state", {30'd0, bus.sched_state}, 32'd0);

    // Load-use through the scoreboard
    drive(1, 0, LW_X5, NOP); lit("lw_x5", 1, 0); tick;
    chk("lw_busy", bus.sb_busy, 32'h0000_0020);
    drive(1, 0, ADD_X6_X5, NOP); lit("use_a", 0, 0); tick;
    lit("use_b", 0, 0);
    bus.wb_ld_valid = 1'b1; bus.wb_ld_rd = 5'd5; lit("use_wb", 0, 0); tick;
    bus.wb_ld_valid = 1'b0;
    chk("wb_clear", bus.sb_busy, 32'd0);
    lit("use_go", 1, 0); tick;

    // Set and clear of x5 in the same cycle: set wins
    drive(1, 0, LW_X5, NOP);
    bus.wb_ld_valid = 1'b1; bus.wb_ld_rd = 5'd5; lit("setclr", 1, 0); tick;
    bus.wb_ld_valid = 1'b0;
    chk("setclr_busy", bus.sb_busy, 32'h0000_0020);
    drive(1, 0, NOP, NOP);
    bus.wb_ld_valid = 1'b1; tick;
    bus.wb_ld_valid = 1'b0;
    chk("clr_busy", bus.sb_busy, 32'd0);

    // Branch flush leaves the scoreboard alone
    drive(1, 0, LW_X7, NOP); tick;
    chk("lw_x7_busy", bus.sb_busy, 32'h0000_0080);
    drive(1, 1, ADDI_X1, ADDI_X3);
    bus.branch_flag = 1'b1; lit("branch", 0, 0); tick;
    bus.branch_flag = 1'b0;
    chk("flush_state", {30'd0, bus.sched_state}, 32'd1);
    lit("flush_hold", 0, 0); tick;
    chk("after_flush_state", {30'd0, bus.sched_state}, 32'd0);
    chk("after_flush_busy", bus.sb_busy, 32'h0000_0080);
    lit("after_flush", 1, DUAL); tick;

    // Fence waits for the scoreboard, then drains
    drive(1, 1, FENCE, NOP); lit("fence_wait", 0, 0); tick;
    bus.wb_ld_valid = 1'b1; bus.wb_ld_rd = 5'd7; lit("fence_wb", 0, 0); tick;
    bus.wb_ld_valid = 1'b0;
    lit("fence_go", 1, 0); tick;
    drive(1, 0, NOP, NOP);
    for (int k = 0; k < DRAIN_N; k++) begin
      chk("drain_state", {30'd0, bus.sched_state}, 32'd2);
      lit("drain_hold", 0, 0);
      tick;
    end
    chk("drain_done", {30'd0, bus.sched_state}, 32'd0);
    lit("drain_run", 1, 0); tick;

    // Pair rules: two memory ops, control in slot 0
    drive(1, 1, LW_X5, SW_X1);  lit("mem_pair", 1, 0); tick;
    bus.wb_ld_valid = 1'b1; bus.wb_ld_rd = 5'd5;
    drive(1, 1, JAL_X0, NOP);   lit("ctrl_pair", 1, 0); tick;
    bus.wb_ld_valid = 1'b0;
    drive(0, 0, NOP, NOP);
    tick; tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
